add_serial: RTL and testbench

ADD_SERIAL -- requirements
Module: add_serial

---
 rtl/add_serial.sv | 121 ++++++++++++
 tb/tb_add_serial.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial.sv
// Digit-serial adder/subtractor.
// Processes DIGIT bits per cycle, LSB slice first, with registered results.
module add_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic [DIGIT-1:0] a_sl;
   logic [DIGIT-1:0] b_sl;
   logic [DIGIT-1:0] s_sl;
   logic [DIGIT:0]   s_ext;
   logic             msb_cin;
   int               idx;

   // Current slice sum; carry into the slice MSB is recovered from a^b^s.
   always_comb begin
      idx     = int'(cnt_q) * DIGIT;
      a_sl    = a_q[idx +: DIGIT];
      b_sl    = b_q[idx +: DIGIT];
      s_ext   = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
      s_sl    = s_ext[DIGIT-1:0];
      msb_cin = s_sl[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
      sum_d   = sum_q;
      sum_d[idx +: DIGIT] = s_sl;
   end

   // Control FSM with registered datapath and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= c_in ^ sub;
                  cnt_q   <= '0;
                  sum_q   <= '0;
                  c_out_q <= 1'b0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               carry_q <= s_ext[DIGIT];
               if (cnt_q == LAST) begin
                  c_out_q <= s_ext[DIGIT];
                  ovf_q   <= msb_cin ^ s_ext[DIGIT];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sum      = sum_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_add_serial.sv
// Directed bench for add_serial.
// Seven instances: WIDTH=8 DIGIT{1,4}, WIDTH=16 DIGIT{1,2,4,8,16}.
`timescale 1ns/1ps
module tb_add_serial;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [6:0]  start_v;
   logic        sub;
   logic        c_in;
   logic [15:0] a;
   logic [15:0] b;

   logic [15:0] sum_a  [7];
   logic        co_a   [7];
   logic        ov_a   [7];
   logic        busy_a [7];
   logic        done_a [7];
   logic [7:0]  s8     [2];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   add_serial #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub),
      .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .sum(s8[0]),
      .c_out(co_a[0]), .overflow(ov_a[0]),
      .busy(busy_a[0]), .done(done_a[0])
   );

   add_serial #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub),
      .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .sum(s8[1]),
      .c_out(co_a[1]), .overflow(ov_a[1]),
      .busy(busy_a[1]), .done(done_a[1])
   );

   assign sum_a[0] = {8'h00, s8[0]};
   assign sum_a[1] = {8'h00, s8[1]};

   for (genvar g = 0; g < 5; g++) begin : g_w16
      add_serial #(.WIDTH(16), .DIGIT(1 << g)) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start_v[g+2]), .sub(sub),
         .a(a), .b(b), .c_in(c_in), .sum(sum_a[g+2]),
         .c_out(co_a[g+2]), .overflow(ov_a[g+2]),
         .busy(busy_a[g+2]), .done(done_a[g+2])
      );
   end

   function automatic int width_of(input int k);
      return (k < 2) ? 8 : 16;
   endfunction

   function automatic int digit_of(input int k);
      if (k == 0) return 1;
      if (k == 1) return 4;
      return 1 << (k - 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: widen, add, take carry and sign rule for overflow.
   task automatic ref_model(input int w, input logic [15:0] ta,
                            input logic [15:0] tb, input logic ts,
                            input logic tc, output logic [15:0] s,
                            output logic co, output logic ov);
      logic [16:0] mask, aa, bb, full;
      mask = (17'd1 << w) - 17'd1;
      aa   = {1'b0, ta} & mask;
      bb   = (ts ? ~{1'b0, tb} : {1'b0, tb}) & mask;
      full = aa + bb + {16'h0000, ts ? ~tc : tc};
      s    = full[15:0] & mask[15:0];
      co   = full[w];
      ov   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
   endtask

   task automatic run_op(input int k, input string tag,
                         input logic [15:0] ta, input logic [15:0] tb,
                         input logic ts, input logic tc, input int glitch,
                         input logic [15:0] es, input logic eco,
                         input logic eov);
      int lat;
      int n;
      n = width_of(k) / digit_of(k);
      a = ta; b = tb; sub = ts; c_in = tc;
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      lat = 0;
      while (busy_a[k] && lat < 100) begin
         lat++;
         if (lat == glitch) begin
            start_v[k] = 1'b1;
            a = ~ta; b = tb ^ 16'h5A5A; sub = ~ts;
         end else begin
            start_v[k] = 1'b0;
         end
         @(negedge clk);
      end
      start_v[k] = 1'b0;
      chk({tag, " busy_cycles"}, lat, n);
      chk({tag, " done"}, 32'(done_a[k]), 1);
      chk({tag, " sum"}, 32'(sum_a[k]), 32'(es));
      chk({tag, " c_out"}, 32'(co_a[k]), 32'(eco));
      chk({tag, " overflow"}, 32'(ov_a[k]), 32'(eov));
      @(negedge clk);
      chk({tag, " done_pulse_end"}, 32'(done_a[k]), 0);
      chk({tag, " idle_busy"}, 32'(busy_a[k]), 0);
      chk({tag, " sum_hold"}, 32'(sum_a[k]), 32'(es));
   endtask

   task automatic b2b(input int k, input string tag,
                      input logic [15:0] a1, input logic [15:0] b1,
                      input logic s1, input logic c1,
                      input logic [15:0] a2, input logic [15:0] b2,
                      input logic s2, input logic c2);
      int n, t, nd, t1, t2;
      logic [15:0] e1, e2, r1, r2;
      logic eco1, eco2, eov1, eov2, rc1, rc2;
      n = width_of(k) / digit_of(k);
      ref_model(width_of(k), a1, b1, s1, c1, e1, eco1, eov1);
      ref_model(width_of(k), a2, b2, s2, c2, e2, eco2, eov2);
      t1 = -1; t2 = -1; r1 = '0; r2 = '0; rc1 = 1'b0; rc2 = 1'b0;
      a = a1; b = b1; sub = s1; c_in = c1;
      start_v[k] = 1'b1;
      @(negedge clk);
      a = a2; b = b2; sub = s2; c_in = c2;
      t = 1; nd = 0;
      while (t <= 3 * n + 8) begin
         if (done_a[k]) begin
            nd++;
            if (nd == 1) begin
               t1 = t; r1 = sum_a[k]; rc1 = co_a[k];
            end else if (nd == 2) begin
               t2 = t; r2 = sum_a[k]; rc2 = co_a[k];
            end
         end else if (nd == 1) begin
            start_v[k] = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      start_v[k] = 1'b0;
      chk({tag, " done_count"}, nd, 2);
      chk({tag, " first_done_at"}, t1, n + 1);
      chk({tag, " done_spacing"}, t2 - t1, n + 1);
      chk({tag, " sum1"}, 32'(r1), 32'(e1));
      chk({tag, " c_out1"}, 32'(rc1), 32'(eco1));
      chk({tag, " sum2"}, 32'(r2), 32'(e2));
      chk({tag, " c_out2"}, 32'(rc2), 32'(eco2));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] es, ra, rb, ra2, rb2;
      logic eco, eov, rs, rc, rs2, rc2;
      logic seen;
      start_v = '0;
      a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("reset_sum%0d", k), 32'(sum_a[k]), 0);
         chk($sformatf("reset_flags%0d", k),
             {28'd0, co_a[k], ov_a[k], busy_a[k], done_a[k]}, 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(0, "r028", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0,
             16'h0000, 1'b1, 1'b0);
      run_op(0, "r029a", 16'h007F, 16'h0001, 1'b0, 1'b0, 0,
             16'h0080, 1'b0, 1'b1);
      run_op(0, "r029b", 16'h0005, 16'h0007, 1'b1, 1'b0, 0,
             16'h00FE, 1'b0, 1'b0);
      run_op(1, "r030", 16'h003C, 16'h000F, 1'b0, 1'b1, 0,
             16'h004C, 1'b0, 1'b0);
      run_op(0, "r031", 16'h0012, 16'h0034, 1'b0, 1'b0, 3,
             16'h0046, 1'b0, 1'b0);

      a = 16'h0055; b = 16'h002A; sub = 1'b0; c_in = 1'b0;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("r032 busy_before_reset", 32'(busy_a[0]), 1);
      rst_n = 1'b0;
      #1;
      chk("r032 reset_sum", 32'(sum_a[0]), 0);
      chk("r032 reset_flags",
          {28'd0, co_a[0], ov_a[0], busy_a[0], done_a[0]}, 0);
      #3 rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_a[0] || busy_a[0]) seen = 1'b1;
      end
      chk("r032 no_done_after_abort", 32'(seen), 0);
      run_op(0, "r032b", 16'h0055, 16'h002A, 1'b0, 1'b0, 0,
             16'h007F, 1'b0, 1'b0);

      for (int k = 2; k < 7; k++) begin
         run_op(k, $sformatf("w16d%0d_edge", digit_of(k)),
                16'h8000, 16'h0001, 1'b1, 1'b1, 0,
                16'h7FFE, 1'b1, 1'b1);
         run_op(k, $sformatf("w16d%0d_wrap", digit_of(k)),
                16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 0,
                16'hFFFF, 1'b1, 1'b0);
      end

      for (int k = 2; k < 7; k++) begin
         for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ref_model(16, ra, rb, rs, rc, es, eco, eov);
            run_op(k, $sformatf("rand_d%0d_%0d", digit_of(k), i),
                   ra, rb, rs, rc, 0, es, eco, eov);
         end
      end

      for (int k = 0; k < 7; k++) begin
         ra  = 16'($urandom); rb  = 16'($urandom);
         ra2 = 16'($urandom); rb2 = 16'($urandom);
         rs  = 1'($urandom_range(0, 1)); rc  = 1'($urandom_range(0, 1));
         rs2 = 1'($urandom_range(0, 1)); rc2 = 1'($urandom_range(0, 1));
         b2b(k, $sformatf("b2b_w%0dd%0d", width_of(k), digit_of(k)),
             ra, rb, rs, rc, ra2, rb2, rs2, rc2);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
